psw_jk_reg: RTL and testbench

- Parametrised program-status-word register; successor to the fixed 16-bit per-bit JKFF PSW block.
- Each bit is a JK flip-flop. On top of that it adds:
  - a masked bus write port,
  - a masked ALU flag-update port,
  - a one-level shadow copy for interrupt entry and return,
  - sticky rising-edge event pending bits that drive an interrupt request.
- Sits beside the ALU as R5. The datapath reads Q directly and the interrupt controller consumes irq.

---
 rtl/psw_jk_if.sv | 36 +++
 rtl/psw_jk_reg.sv | 96 +++++++++
 tb/tb_psw_jk_reg.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/psw_jk_if.sv
// Bus bundle for the PSW register: JK requests, bus write, ALU flag update,
// shadow control, event acknowledge and the registered status outputs.
interface psw_jk_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] J;
   logic [WIDTH-1:0] K;
   logic             wr_en;
   logic [WIDTH-1:0] wr_mask;
   logic [WIDTH-1:0] wr_data;
   logic             flg_we;
   logic [WIDTH-1:0] flg_mask;
   logic [WIDTH-1:0] flg_val;
   logic             save;
   logic             restore;
   logic [WIDTH-1:0] ack;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] pend;
   logic             irq;
   logic             shadow_vld;
   logic             rst_err;

   // Level-sensitive strobes, sampled on every rising clock edge; no
   // valid/ready handshake, each request takes effect in the cycle it is seen.
   modport slave (
      input  J, K, wr_en, wr_mask, wr_data, flg_we, flg_mask, flg_val,
             save, restore, ack,
      output Q, pend, irq, shadow_vld, rst_err
   );

   modport master (
      output J, K, wr_en, wr_mask, wr_data, flg_we, flg_mask, flg_val,
             save, restore, ack,
      input  Q, pend, irq, shadow_vld, rst_err
   );
endinterface

// File: rtl/psw_jk_reg.sv
// Program status word built from per-bit JK flip-flops with masked bus write,
// masked ALU flag update, one-level shadow for interrupts and sticky events.
module psw_jk_reg #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] IRQ_MASK    = '0
) (
   input  logic      clk,
   input  logic      clr_n,
   psw_jk_if.slave   bus
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_shadow;
   logic             r_shadow_vld;
   logic [WIDTH-1:0] r_pend;
   logic             r_rst_err;

   logic             w_restore_ok;
   logic             w_save_ok;
   logic             w_rst_err;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_pend_next;
   logic             w_shadow_vld_next;
   logic [WIDTH-1:0] w_shadow_next;

   // A restore without a saved value degrades to a normal cycle plus an error.
   always_comb begin
      w_restore_ok = bus.restore && r_shadow_vld;
      w_save_ok    = bus.save && !w_restore_ok;
      w_rst_err    = bus.restore && !r_shadow_vld;
   end

   always_comb begin
      w_q_next = r_q;
      if (w_restore_ok) begin
         w_q_next = r_shadow;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (bus.wr_en && bus.wr_mask[i]) begin
               w_q_next[i] = bus.wr_data[i];
            end else if (bus.J[i] || bus.K[i]) begin
               case ({bus.J[i], bus.K[i]})
                  2'b10:   w_q_next[i] = 1'b1;
                  2'b01:   w_q_next[i] = 1'b0;
                  default: w_q_next[i] = ~r_q[i];
               endcase
            end else if (bus.flg_we && bus.flg_mask[i]) begin
               w_q_next[i] = bus.flg_val[i];
            end
         end
      end
   end

   // Shadow captures the pre-update Q; a good restore consumes it.
   always_comb begin
      w_shadow_next     = r_shadow;
      w_shadow_vld_next = r_shadow_vld;
      if (w_restore_ok) begin
         w_shadow_vld_next = 1'b0;
      end else if (w_save_ok) begin
         w_shadow_next     = r_q;
         w_shadow_vld_next = 1'b1;
      end
   end

   // A fresh rise wins over an acknowledge on the same bit.
   always_comb begin
      w_rise      = w_q_next & ~r_q & IRQ_MASK;
      w_pend_next = (r_pend & ~bus.ack) | w_rise;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_q          <= RESET_VALUE;
         r_shadow     <= '0;
         r_shadow_vld <= 1'b0;
         r_pend       <= '0;
         r_rst_err    <= 1'b0;
      end else begin
         r_q          <= w_q_next;
         r_shadow     <= w_shadow_next;
         r_shadow_vld <= w_shadow_vld_next;
         r_pend       <= w_pend_next;
         r_rst_err    <= w_rst_err;
      end
   end

   assign bus.Q          = r_q;
   assign bus.pend       = r_pend;
   assign bus.irq        = |r_pend;
   assign bus.shadow_vld = r_shadow_vld;
   assign bus.rst_err    = r_rst_err;

endmodule

// File: tb/tb_psw_jk_reg.sv
// Directed bench for psw_jk_reg (WIDTH=16, IRQ_MASK=16'h0003, RESET_VALUE=0):
// JK table, priority, shadow, events, masked bits and async reset.
module tb_psw_jk_reg;

   logic clk;
   logic clr_n;
   int   total;
   int   bad;

   psw_jk_if #(.WIDTH(16)) bus ();

   psw_jk_reg #(
      .WIDTH       (16),
      .RESET_VALUE (16'h0000),
      .IRQ_MASK    (16'h0003)
   ) u_dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.J = '0; bus.K = '0;
      bus.wr_en = 1'b0; bus.wr_mask = '0; bus.wr_data = '0;
      bus.flg_we = 1'b0; bus.flg_mask = '0; bus.flg_val = '0;
      bus.save = 1'b0; bus.restore = 1'b0; bus.ack = '0;
   endtask

   task automatic wr_all(input logic [15:0] d);
      idle();
      bus.wr_en = 1'b1; bus.wr_mask = 16'hFFFF; bus.wr_data = d;
      tick();
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clr_n = 1'b0;
      idle();
      #2;
      chk("reset_q", bus.Q, 16'h0000);
      chk("reset_pend", bus.pend, 16'h0000);
      chk("reset_vld", {15'd0, bus.shadow_vld}, 16'd0);
      chk("reset_irq", {15'd0, bus.irq}, 16'd0);
      chk("reset_err", {15'd0, bus.rst_err}, 16'd0);
      #5 clr_n = 1'b1;

      // JK truth table
      bus.J = 16'h000F; bus.K = 16'h00F0;
      tick();
      chk("jk_set", bus.Q, 16'h000F);
      chk("jk_set_pend", bus.pend, 16'h0003);
      bus.J = 16'h0011; bus.K = 16'h0011;
      tick();
      chk("jk_toggle", bus.Q, 16'h001E);
      idle();
      tick();
      tick();
      chk("jk_hold", bus.Q, 16'h001E);
      bus.ack = 16'h0003;
      tick();
      idle();
      chk("ack_all", bus.pend, 16'h0000);

      // Priority: write over JK over flag update
      wr_all(16'h00FF);
      chk("prio_setup", bus.Q, 16'h00FF);
      chk("prio_setup_pend", bus.pend, 16'h0001);
      bus.wr_en = 1'b1; bus.wr_mask = 16'h000F; bus.wr_data = 16'h0000;
      bus.K = 16'h00FF;
      bus.flg_we = 1'b1; bus.flg_mask = 16'hFFFF; bus.flg_val = 16'hFF00;
      bus.ack = 16'h0001;
      tick();
      idle();
      chk("prio_q", bus.Q, 16'hFF00);
      chk("prio_pend", bus.pend, 16'h0000);

      // Rising bits outside IRQ_MASK never become events
      wr_all(16'hFFFC);
      chk("nonevt_q", bus.Q, 16'hFFFC);
      chk("nonevt_pend", bus.pend, 16'h0000);
      chk("nonevt_irq", {15'd0, bus.irq}, 16'd0);

      // Shadow save / restore / bad restore
      wr_all(16'h1234);
      chk("shd_setup", bus.Q, 16'h1234);
      bus.save = 1'b1; bus.J = 16'h0001;
      tick();
      idle();
      chk("shd_save_q", bus.Q, 16'h1235);
      chk("shd_save_vld", {15'd0, bus.shadow_vld}, 16'd1);
      bus.restore = 1'b1;
      tick();
      idle();
      chk("shd_rest_q", bus.Q, 16'h1234);
      chk("shd_rest_vld", {15'd0, bus.shadow_vld}, 16'd0);
      bus.restore = 1'b1;
      tick();
      idle();
      chk("shd_err_pulse", {15'd0, bus.rst_err}, 16'd1);
      chk("shd_err_q", bus.Q, 16'h1234);
      tick();
      chk("shd_err_clear", {15'd0, bus.rst_err}, 16'd0);
      chk("shd_err_q2", bus.Q, 16'h1234);
      bus.ack = 16'h0001;
      tick();
      idle();
      chk("shd_ack", bus.pend, 16'h0000);

      // Events: rise, ack collision, ack clear
      wr_all(16'h0000);
      bus.J = 16'h0003;
      tick();
      idle();
      chk("evt_q", bus.Q, 16'h0003);
      chk("evt_pend", bus.pend, 16'h0003);
      chk("evt_irq", {15'd0, bus.irq}, 16'd1);
      bus.K = 16'h0001;
      tick();
      idle();
      chk("evt_fall_q", bus.Q, 16'h0002);
      chk("evt_fall_pend", bus.pend, 16'h0003);
      bus.J = 16'h0001; bus.ack = 16'h0001;
      tick();
      idle();
      chk("evt_collide_q", bus.Q, 16'h0003);
      chk("evt_collide_pend", bus.pend, 16'h0003);
      bus.ack = 16'h0003;
      tick();
      idle();
      chk("evt_ack_pend", bus.pend, 16'h0000);
      chk("evt_ack_irq", {15'd0, bus.irq}, 16'd0);

      // Restore beats write/JK and same-cycle save; its rises are events
      bus.save = 1'b1;
      tick();
      idle();
      chk("rs_save_vld", {15'd0, bus.shadow_vld}, 16'd1);
      wr_all(16'h0000);
      chk("rs_clear_q", bus.Q, 16'h0000);
      bus.restore = 1'b1; bus.save = 1'b1;
      bus.wr_en = 1'b1; bus.wr_mask = 16'hFFFF; bus.wr_data = 16'hFFFF;
      bus.J = 16'hFFFF;
      tick();
      idle();
      chk("rs_q", bus.Q, 16'h0003);
      chk("rs_vld", {15'd0, bus.shadow_vld}, 16'd0);
      chk("rs_pend", bus.pend, 16'h0003);
      bus.ack = 16'h0003;
      tick();
      idle();

      // Async reset between edges
      wr_all(16'hABCD);
      bus.wr_en = 1'b1; bus.wr_mask = 16'h0002; bus.wr_data = 16'h0002;
      tick();
      idle();
      bus.K = 16'h0002; bus.save = 1'b1;
      tick();
      idle();
      chk("ar_pre_q", bus.Q, 16'hABCD);
      chk("ar_pre_pend", bus.pend, 16'h0002);
      chk("ar_pre_vld", {15'd0, bus.shadow_vld}, 16'd1);
      #2 clr_n = 1'b0;
      #1;
      chk("ar_q", bus.Q, 16'h0000);
      chk("ar_pend", bus.pend, 16'h0000);
      chk("ar_vld", {15'd0, bus.shadow_vld}, 16'd0);
      chk("ar_irq", {15'd0, bus.irq}, 16'd0);
      #2 clr_n = 1'b1;
      tick();
      chk("ar_post_pend", bus.pend, 16'h0000);
      chk("ar_post_q", bus.Q, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
